// File: rtl/pfu_pkg.sv
// Shared constants and port-select encoding for the pfu demux family.
package pfu_pkg;

  localparam int PFU_DEMUX2_CNT_W = 8;

  typedef enum logic {
    SEL_B = 1'b0,
    SEL_A = 1'b1
  } pfu_sel_e;

  function automatic pfu_sel_e pfu_sel(input logic i_c0);
    return pfu_sel_e'(i_c0);
  endfunction

endpackage

// File: rtl/pfu_demux2_slot.sv
// One-entry output register with valid/ready; latency 1, refills in the same cycle it drains.
module pfu_demux2_slot #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_vld,
  output logic             o_rdy,
  input  logic [WIDTH-1:0] i_dat,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_dat,
  input  logic             i_rdy
);

  logic             r_vld;
  logic [WIDTH-1:0] r_dat;
  logic             w_load;

  assign o_rdy  = !r_vld || i_rdy;
  assign w_load = i_vld && o_rdy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (w_load) begin
      r_vld <= 1'b1;
      r_dat <= i_dat;
    end else if (i_rdy) begin
      // Drain without refill; data is left as-is.
      r_vld <= 1'b0;
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;

endmodule

// File: rtl/pfu_demux2.sv
// 1:2 valid/ready demux, latency 1, stalls input only when the selected port is full and blocked.
// Define PFU_DEMUX2_CNT_EN to add per-port 8-bit output-transfer counters CNTA/CNTB.
module pfu_demux2
  import pfu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] DIN,
  input  logic             C0,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic [WIDTH-1:0] ZA,
  output logic             ZA_VALID,
  input  logic             ZA_READY,
  output logic [WIDTH-1:0] ZB,
  output logic             ZB_VALID,
  input  logic             ZB_READY
`ifdef PFU_DEMUX2_CNT_EN
  ,
  output logic [PFU_DEMUX2_CNT_W-1:0] CNTA,
  output logic [PFU_DEMUX2_CNT_W-1:0] CNTB
`endif
);

  pfu_sel_e w_sel;
  logic     w_vld_a;
  logic     w_vld_b;
  logic     w_rdy_a;
  logic     w_rdy_b;

  assign w_sel     = pfu_sel(C0);
  assign w_vld_a   = DIN_VALID && (w_sel == SEL_A);
  assign w_vld_b   = DIN_VALID && (w_sel == SEL_B);
  assign DIN_READY = (w_sel == SEL_A) ? w_rdy_a : w_rdy_b;

  pfu_demux2_slot #(.WIDTH(WIDTH)) u_slot_a (
    .i_clk   (CLK),
    .i_rst_n (RSTN),
    .i_vld   (w_vld_a),
    .o_rdy   (w_rdy_a),
    .i_dat   (DIN),
    .o_vld   (ZA_VALID),
    .o_dat   (ZA),
    .i_rdy   (ZA_READY)
  );

  pfu_demux2_slot #(.WIDTH(WIDTH)) u_slot_b (
    .i_clk   (CLK),
    .i_rst_n (RSTN),
    .i_vld   (w_vld_b),
    .o_rdy   (w_rdy_b),
    .i_dat   (DIN),
    .o_vld   (ZB_VALID),
    .o_dat   (ZB),
    .i_rdy   (ZB_READY)
  );

`ifdef PFU_DEMUX2_CNT_EN
  logic [PFU_DEMUX2_CNT_W-1:0] r_cnt_a;
  logic [PFU_DEMUX2_CNT_W-1:0] r_cnt_b;

  // Counters wrap naturally at 2**PFU_DEMUX2_CNT_W.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else begin
      if (ZA_VALID && ZA_READY) r_cnt_a <= r_cnt_a + PFU_DEMUX2_CNT_W'(1);
      if (ZB_VALID && ZB_READY) r_cnt_b <= r_cnt_b + PFU_DEMUX2_CNT_W'(1);
    end
  end

  assign CNTA = r_cnt_a;
  assign CNTB = r_cnt_b;
`endif

endmodule

// File: tb/tb_pfu_demux2.sv
// Scoreboard bench for pfu_demux2: driver pushes expected words per port, negedge monitor pops and compares.
module tb_pfu_demux2;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic [7:0] DIN = 8'h00;
  logic       C0 = 1'b0;
  logic       DIN_VALID = 1'b0;
  logic       DIN_READY;
  logic [7:0] ZA;
  logic       ZA_VALID;
  logic       ZA_READY = 1'b0;
  logic [7:0] ZB;
  logic       ZB_VALID;
  logic       ZB_READY = 1'b0;
`ifdef PFU_DEMUX2_CNT_EN
  logic [7:0] CNTA;
  logic [7:0] CNTB;
`endif

  int n_vec = 0;
  int n_err = 0;
  int na_pop = 0;
  int nb_pop = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  always #5 CLK = ~CLK;

  pfu_demux2 #(.WIDTH(8)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .DIN       (DIN),
    .C0        (C0),
    .DIN_VALID (DIN_VALID),
    .DIN_READY (DIN_READY),
    .ZA        (ZA),
    .ZA_VALID  (ZA_VALID),
    .ZA_READY  (ZA_READY),
    .ZB        (ZB),
    .ZB_VALID  (ZB_VALID),
    .ZB_READY  (ZB_READY)
`ifdef PFU_DEMUX2_CNT_EN
    ,
    .CNTA      (CNTA),
    .CNTB      (CNTB)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Presents one word; returns at posedge+1 after acceptance with DIN_VALID cleared.
  task automatic send(input logic [7:0] d, input logic c, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    DIN = d;
    C0 = c;
    DIN_VALID = 1'b1;
    while (!ok && waited < 20) begin
      @(negedge CLK);
      if (DIN_READY) ok = 1'b1;
      else waited++;
    end
    @(posedge CLK);
    if (ok) begin
      if (c) qa.push_back(d);
      else   qb.push_back(d);
    end else begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: DIN_READY stayed 0 for %0d cycles, expected 1", waited);
    end
    #1;
    DIN_VALID = 1'b0;
  endtask

  logic       hold_a = 1'b0;
  logic       hold_b = 1'b0;
  logic [7:0] prev_a = 8'h00;
  logic [7:0] prev_b = 8'h00;

  always @(negedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      hold_a = 1'b0;
      hold_b = 1'b0;
    end else begin
      if (hold_a) begin
        chk("za_hold_vld", 32'(ZA_VALID), 32'(1));
        chk("za_hold_dat", 32'(ZA), 32'(prev_a));
      end
      if (hold_b) begin
        chk("zb_hold_vld", 32'(ZB_VALID), 32'(1));
        chk("zb_hold_dat", 32'(ZB), 32'(prev_b));
      end
      if (ZA_VALID && ZA_READY) begin
        if (qa.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL za_unexpected: got %0h, expected no word", ZA);
        end else begin
          chk("za_order", 32'(ZA), 32'(qa.pop_front()));
          na_pop++;
        end
      end
      if (ZB_VALID && ZB_READY) begin
        if (qb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL zb_unexpected: got %0h, expected no word", ZB);
        end else begin
          chk("zb_order", 32'(ZB), 32'(qb.pop_front()));
          nb_pop++;
        end
      end
      hold_a = ZA_VALID && !ZA_READY;
      hold_b = ZB_VALID && !ZB_READY;
      prev_a = ZA;
      prev_b = ZB;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int a0;
    int b0;

    #12;
    chk("rst_za_vld", 32'(ZA_VALID), 32'(0));
    chk("rst_zb_vld", 32'(ZB_VALID), 32'(0));
    chk("rst_za", 32'(ZA), 32'(0));
    chk("rst_zb", 32'(ZB), 32'(0));
    chk("rst_din_rdy", 32'(DIN_READY), 32'(1));
`ifdef PFU_DEMUX2_CNT_EN
    chk("rst_cnta", 32'(CNTA), 32'(0));
    chk("rst_cntb", 32'(CNTB), 32'(0));
`endif
    tick();
    RSTN = 1'b1;
    ZA_READY = 1'b1;
    ZB_READY = 1'b1;

    // Single word to A, accepted on first edge after reset release.
    send(8'h5A, 1'b1, w);
    chk("first_accept_wait", 32'(w), 32'(0));
    @(negedge CLK);
    chk("a_lat_vld", 32'(ZA_VALID), 32'(1));
    chk("a_lat_dat", 32'(ZA), 32'(8'h5A));
    chk("a_lat_zb_vld", 32'(ZB_VALID), 32'(0));
    tick();
    @(negedge CLK);
    chk("a_drained_vld", 32'(ZA_VALID), 32'(0));
    tick();

    // B blocked: A still flows, second B word stalls until B drains.
    ZB_READY = 1'b0;
    send(8'h11, 1'b0, w);
    send(8'h33, 1'b1, w);
    chk("a_pass_b_full_wait", 32'(w), 32'(0));
    @(negedge CLK);
    chk("a_pass_vld", 32'(ZA_VALID), 32'(1));
    chk("a_pass_dat", 32'(ZA), 32'(8'h33));
    chk("b_full_vld", 32'(ZB_VALID), 32'(1));
    chk("b_full_dat", 32'(ZB), 32'(8'h11));
    tick();
    DIN = 8'h22;
    C0 = 1'b0;
    DIN_VALID = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("b_full_stall", 32'(DIN_READY), 32'(0));
      tick();
    end
    ZB_READY = 1'b1;
    send(8'h22, 1'b0, w);
    chk("b_release_wait", 32'(w), 32'(0));
    @(negedge CLK);
    chk("b_refill_vld", 32'(ZB_VALID), 32'(1));
    chk("b_refill_dat", 32'(ZB), 32'(8'h22));
    tick();

    // DIN/C0 toggling without DIN_VALID must not create words.
    repeat (4) begin
      DIN = 8'($urandom);
      C0 = 1'($urandom);
      tick();
    end
    @(negedge CLK);
    chk("idle_za_vld", 32'(ZA_VALID), 32'(0));
    chk("idle_zb_vld", 32'(ZB_VALID), 32'(0));
    tick();

    // Same-port back-to-back: drain and refill in one cycle.
    send(8'hA1, 1'b1, w);
    send(8'hA2, 1'b1, w);
    chk("a_b2b_wait", 32'(w), 32'(0));
    @(negedge CLK);
    chk("a_b2b_vld", 32'(ZA_VALID), 32'(1));
    chk("a_b2b_dat", 32'(ZA), 32'(8'hA2));
    tick();

    // 100 alternating words at full rate.
    a0 = na_pop;
    b0 = nb_pop;
    for (int i = 0; i < 100; i++) begin
      send(8'(i * 3 + 1), i[0], w);
      chk("alt_no_stall", 32'(w), 32'(0));
    end
    repeat (3) tick();
    chk("alt_a_count", 32'(na_pop - a0), 32'(50));
    chk("alt_b_count", 32'(nb_pop - b0), 32'(50));
    chk("alt_qa_empty", 32'(qa.size()), 32'(0));
    chk("alt_qb_empty", 32'(qb.size()), 32'(0));

    // Asynchronous reset while A holds a word.
    ZA_READY = 1'b0;
    send(8'h77, 1'b1, w);
    @(negedge CLK);
    chk("pre_rst_za_vld", 32'(ZA_VALID), 32'(1));
    #2;
    RSTN = 1'b0;
    #1;
    chk("async_rst_za_vld", 32'(ZA_VALID), 32'(0));
    chk("async_rst_za", 32'(ZA), 32'(0));
    chk("async_rst_din_rdy", 32'(DIN_READY), 32'(1));
    qa.delete();
    qb.delete();
    tick();
    RSTN = 1'b1;
    ZA_READY = 1'b1;

`ifdef PFU_DEMUX2_CNT_EN
    chk("cnt_after_rst", 32'(CNTA), 32'(0));
    for (int i = 0; i < 257; i++) begin
      send(8'(i), 1'b1, w);
    end
    repeat (3) tick();
    chk("cnta_wrap", 32'(CNTA), 32'(1));
    chk("cntb_idle", 32'(CNTB), 32'(0));
`endif

    repeat (2) tick();
    chk("end_qa_empty", 32'(qa.size()), 32'(0));
    chk("end_qb_empty", 32'(qb.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
